// File: rtl/matrix_loader_pkg.sv
// Shared constants and state encoding for the matrix loader and the operation controller.
package matrix_loader_pkg;

  localparam int         MATRIX_BITS  = 200;
  localparam int         RAM_WIDTH    = 256;
  localparam int         MATRIX_BYTES = 25;
  localparam logic [7:0] ADDR_A       = 8'd0;
  localparam logic [7:0] ADDR_B       = 8'd1;
  localparam logic [7:0] ADDR_RESULT  = 8'd2;

  typedef enum logic [2:0] {
    IDLE,
    RECV_A,
    WRITE_A,
    RECV_B,
    WRITE_B,
    DONE
  } loader_state_t;

endpackage

// File: rtl/matrix_loader_byte_assembler.sv
// Byte shift buffer with a 5-bit count; shared by matrix A and matrix B reception.
module byte_assembler #(
  parameter int NUM_BYTES = matrix_loader_pkg::MATRIX_BYTES
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   accept,
  input  logic [7:0]             in_byte,
  output logic [8*NUM_BYTES-1:0] next_matrix,
  output logic                   last
);
  import matrix_loader_pkg::*;

  logic [8*NUM_BYTES-1:0] buffer;
  logic [4:0]             byte_count;

  // New bytes enter at the top so that after NUM_BYTES shifts byte 0 sits at [7:0].
  assign next_matrix = {in_byte, buffer[8*NUM_BYTES-1:8]};
  assign last        = accept && (byte_count == 5'(NUM_BYTES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buffer     <= '0;
      byte_count <= '0;
    end else if (clear) begin
      buffer     <= '0;
      byte_count <= '0;
    end else if (accept) begin
      buffer     <= next_matrix;
      byte_count <= last ? 5'd0 : byte_count + 5'd1;
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Receives two 5x5 int8 matrices as a byte stream and writes each as one 256-bit RAM word.
module matrix_loader #(
  parameter int         MATRIX_BYTES = matrix_loader_pkg::MATRIX_BYTES,
  parameter logic [7:0] ADDR_A       = matrix_loader_pkg::ADDR_A,
  parameter logic [7:0] ADDR_B       = matrix_loader_pkg::ADDR_B,
  parameter int         WRITE_HOLD   = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         abort,
  output logic [7:0]   ram_address,
  output logic [255:0] ram_data,
  output logic         ram_wren,
  output logic         busy,
  output logic         matrices_ready
);
  import matrix_loader_pkg::*;

  localparam logic [7:0] HOLD_LAST = 8'(WRITE_HOLD - 1);

  loader_state_t                 state;
  logic [7:0]                    hold_cnt;
  logic                          accept;
  logic                          last;
  logic [8*MATRIX_BYTES-1:0]     next_matrix;

  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE);

  byte_assembler #(
    .NUM_BYTES (MATRIX_BYTES)
  ) u_assembler (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (abort || (state == IDLE)),
    .accept      (accept),
    .in_byte     (in_data),
    .next_matrix (next_matrix),
    .last        (last)
  );

  // Address and data are only reloaded at the start of a write, so they stay put
  // through the whole wren window and afterwards until the next matrix completes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      in_ready       <= 1'b0;
      ram_address    <= '0;
      ram_data       <= '0;
      ram_wren       <= 1'b0;
      matrices_ready <= 1'b0;
      hold_cnt       <= '0;
    end else if (abort) begin
      state          <= IDLE;
      in_ready       <= 1'b0;
      ram_wren       <= 1'b0;
      matrices_ready <= 1'b0;
      hold_cnt       <= '0;
    end else begin
      matrices_ready <= 1'b0;
      case (state)
        IDLE: begin
          state    <= RECV_A;
          in_ready <= 1'b1;
        end
        RECV_A, RECV_B: begin
          if (last) begin
            in_ready    <= 1'b0;
            ram_wren    <= 1'b1;
            hold_cnt    <= '0;
            ram_address <= (state == RECV_A) ? ADDR_A : ADDR_B;
            ram_data    <= RAM_WIDTH'(next_matrix);
            state       <= (state == RECV_A) ? WRITE_A : WRITE_B;
          end
        end
        WRITE_A, WRITE_B: begin
          if (hold_cnt == HOLD_LAST) begin
            ram_wren <= 1'b0;
            hold_cnt <= '0;
            if (state == WRITE_A) begin
              state    <= RECV_B;
              in_ready <= 1'b1;
            end else begin
              state          <= DONE;
              matrices_ready <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed scenarios with randomized bytes and handshake gaps, checked against a RAM-image reference.
module tb_matrix_loader;

  typedef logic [7:0] stream_t [0:49];

  localparam logic [7:0] ADDR_A     = 8'd0;
  localparam logic [7:0] ADDR_B     = 8'd1;
  localparam int         WRITE_HOLD = 2;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   in_data = 8'd0;
  logic         in_valid = 1'b0;
  logic         abort = 1'b0;
  logic         in_ready;
  logic [7:0]   ram_address;
  logic [255:0] ram_data;
  logic         ram_wren;
  logic         busy;
  logic         matrices_ready;

  int compared = 0;
  int mismatched = 0;

  logic [255:0] ram [0:255];
  int           windows[$];
  int           run = 0;
  int           wr_cycles = 0;
  int           b_writes = 0;
  int           ready_pulses = 0;
  logic [7:0]   lat_addr = 8'd0;
  logic [255:0] lat_data = '0;

  always #5 clock = ~clock;

  matrix_loader #(
    .MATRIX_BYTES (25),
    .ADDR_A       (ADDR_A),
    .ADDR_B       (ADDR_B),
    .WRITE_HOLD   (WRITE_HOLD)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .abort          (abort),
    .ram_address    (ram_address),
    .ram_data       (ram_data),
    .ram_wren       (ram_wren),
    .busy           (busy),
    .matrices_ready (matrices_ready)
  );

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] pack(input stream_t s, input int base);
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < 25; k++) r[8*k +: 8] = s[base + k];
    return r;
  endfunction

  // RAM model plus write-window bookkeeping, sampled on the active edge before outputs update.
  always @(posedge clock) begin
    if (ram_wren) begin
      ram[ram_address] = ram_data;
      wr_cycles++;
      if (ram_address == ADDR_B) b_writes++;
      if (run == 0) begin
        lat_addr = ram_address;
        lat_data = ram_data;
      end else begin
        checkOutput("wr_addr_stable", 256'(ram_address), 256'(lat_addr));
        checkOutput("wr_data_stable", ram_data, lat_data);
      end
      run++;
    end else if (run != 0) begin
      checkOutput("post_addr_stable", 256'(ram_address), 256'(lat_addr));
      checkOutput("post_data_stable", ram_data, lat_data);
      windows.push_back(run);
      run = 0;
    end
    if (matrices_ready) ready_pulses++;
  end

  task automatic clearModel();
    for (int i = 0; i < 256; i++) ram[i] = '0;
    windows.delete();
    wr_cycles    = 0;
    b_writes     = 0;
    ready_pulses = 0;
  endtask

  // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid
  task automatic applyStimulus(input stream_t s, input int n, input int mode, input bit abort_last);
    int  idx;
    int  cyc;
    bit  phase;
    bit  take;
    idx   = 0;
    cyc   = 0;
    phase = 1'b1;
    while (idx < n && cyc < 2000) begin
      @(negedge clock);
      if (ram_wren) checkOutput("in_ready_during_write", 256'(in_ready), 256'(1'b0));
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = phase;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      phase   = ~phase;
      in_data = in_valid ? s[idx] : 8'($urandom);
      take    = in_valid && in_ready;
      abort   = abort_last && (idx == n - 1) && take;
      @(posedge clock);
      if (take) idx++;
      cyc++;
    end
    #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    checkOutput("bytes_sent", 256'(idx), 256'(n));
  endtask

  task automatic finishLoad(input stream_t s);
    int cyc;
    cyc = 0;
    while (ready_pulses == 0 && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
    repeat (4) @(negedge clock);
    checkOutput("ready_pulses", 256'(ready_pulses), 256'(1));
    checkOutput("ram_a", ram[ADDR_A], pack(s, 0));
    checkOutput("ram_b", ram[ADDR_B], pack(s, 25));
    checkOutput("window_count", 256'(windows.size()), 256'(2));
    for (int i = 0; i < windows.size(); i++)
      checkOutput("window_len", 256'(windows[i]), 256'(WRITE_HOLD));
    checkOutput("busy_restarted", 256'(busy), 256'(1'b1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    stream_t seq;
    stream_t rnd;
    int      cyc;

    for (int i = 0; i < 50; i++) seq[i] = 8'(i + 1);
    clearModel();

    #2;
    checkOutput("rst_in_ready", 256'(in_ready), 256'(1'b0));
    checkOutput("rst_wren", 256'(ram_wren), 256'(1'b0));
    checkOutput("rst_busy", 256'(busy), 256'(1'b0));
    checkOutput("rst_addr", 256'(ram_address), 256'(8'd0));
    checkOutput("rst_data", ram_data, 256'(0));
    checkOutput("rst_ready", 256'(matrices_ready), 256'(1'b0));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("first_edge_busy", 256'(busy), 256'(1'b1));
    checkOutput("first_edge_in_ready", 256'(in_ready), 256'(1'b1));

    $display("[TB] continuous stream 1..50");
    clearModel();
    applyStimulus(seq, 50, 0, 1'b0);
    finishLoad(seq);

    $display("[TB] alternating valid stream 1..50");
    clearModel();
    applyStimulus(seq, 50, 1, 1'b0);
    finishLoad(seq);

    $display("[TB] abort after ten bytes of A, then random reload");
    for (int i = 0; i < 50; i++) rnd[i] = 8'($urandom);
    clearModel();
    applyStimulus(rnd, 10, 2, 1'b0);
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    checkOutput("abort_busy", 256'(busy), 256'(1'b0));
    checkOutput("abort_in_ready", 256'(in_ready), 256'(1'b0));
    @(negedge clock);
    checkOutput("abort_restart_busy", 256'(busy), 256'(1'b1));
    checkOutput("abort_no_write", 256'(wr_cycles), 256'(0));
    for (int i = 0; i < 50; i++) rnd[i] = 8'($urandom);
    applyStimulus(rnd, 50, 2, 1'b0);
    finishLoad(rnd);

    $display("[TB] reset during first write cycle of B");
    for (int i = 0; i < 50; i++) rnd[i] = 8'($urandom);
    clearModel();
    applyStimulus(rnd, 50, 0, 1'b0);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!(ram_wren && ram_address == ADDR_B) && cyc < 20);
    checkOutput("b_wren_seen", 256'(ram_wren), 256'(1'b1));
    checkOutput("b_first_cycle", 256'(b_writes), 256'(0));
    #1 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_wren", 256'(ram_wren), 256'(1'b0));
    checkOutput("mid_rst_addr", 256'(ram_address), 256'(8'd0));
    checkOutput("mid_rst_data", ram_data, 256'(0));
    checkOutput("mid_rst_in_ready", 256'(in_ready), 256'(1'b0));
    checkOutput("mid_rst_busy", 256'(busy), 256'(1'b0));
    checkOutput("mid_rst_ready", 256'(matrices_ready), 256'(1'b0));
    checkOutput("ram_a_before_rst", ram[ADDR_A], pack(rnd, 0));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("rst_restart_busy", 256'(busy), 256'(1'b1));
    checkOutput("rst_restart_in_ready", 256'(in_ready), 256'(1'b1));

    $display("[TB] abort coinciding with final byte of B");
    for (int i = 0; i < 50; i++) rnd[i] = 8'($urandom);
    clearModel();
    applyStimulus(rnd, 50, 2, 1'b1);
    repeat (8) @(negedge clock);
    checkOutput("abort_last_no_b_write", 256'(b_writes), 256'(0));
    checkOutput("abort_last_no_ready", 256'(ready_pulses), 256'(0));
    checkOutput("abort_last_ram_a", ram[ADDR_A], pack(rnd, 0));
    checkOutput("abort_last_windows", 256'(windows.size()), 256'(1));
    checkOutput("abort_last_in_ready", 256'(in_ready), 256'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
